// File: rtl/ixu_pkg.sv
// Shared types and constants for the integer issue stage.
package ixu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluXor  = 4'd2,
    AluOr   = 4'd3,
    AluAnd  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  localparam logic [6:0] OpcOp    = 7'h33;
  localparam logic [6:0] OpcOpImm = 7'h13;

  localparam logic [6:0] F7Base = 7'h00;
  localparam logic [6:0] F7Alt  = 7'h20;

  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    alu_op_e         op;
    logic [4:0]      rd;
  } issue_entry_t;

  // x0 always reads as zero; otherwise a matching writeback wins over the register file.
  function automatic logic [XLEN-1:0] read_operand(input logic [4:0]      idx,
                                                   input logic [XLEN-1:0] rf_data,
                                                   input logic            wb_valid,
                                                   input logic [4:0]      wb_rd,
                                                   input logic [XLEN-1:0] wb_data);
    if (idx == 5'd0) begin
      return '0;
    end else if (wb_valid && (wb_rd == idx)) begin
      return wb_data;
    end else begin
      return rf_data;
    end
  endfunction

endpackage

// File: rtl/ixu_decode.sv
// Combinational RV32I OP / OP-IMM decoder producing ALU op and immediate.
module ixu_decode
  import ixu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_e     op,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic        is_shift,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_imm;
  logic       f7_base;
  logic       f7_alt;
  logic       unused_instr;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign is_op   = (opcode == OpcOp);
  assign is_imm  = (opcode == OpcOpImm);
  assign f7_base = (funct7 == F7Base);
  assign f7_alt  = (funct7 == F7Alt);
  assign imm     = {{20{instr[31]}}, instr[31:20]};
  assign unused_instr = ^instr[19:7];

  // Map funct3/funct7 to an ALU op and flag encodings outside OP/OP-IMM.
  always_comb begin
    op      = AluAdd;
    use_imm = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000: op = (is_op && f7_alt) ? AluSub : AluAdd;  // OP-IMM has no SUB form
      3'b001: op = AluSll;
      3'b010: op = AluSlt;
      3'b011: op = AluSltu;
      3'b100: op = AluXor;
      3'b101: op = f7_alt ? AluSra : AluSrl;
      3'b110: op = AluOr;
      3'b111: op = AluAnd;
    endcase
    if (is_op) begin
      illegal = !(f7_base || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101))));
    end else if (is_imm) begin
      use_imm = 1'b1;
      if (funct3 == 3'b001) begin
        illegal = !f7_base;
      end else if (funct3 == 3'b101) begin
        illegal = !(f7_base || f7_alt);
      end
    end else begin
      illegal = 1'b1;
    end
  end

  assign is_shift = (op == AluSll) || (op == AluSrl) || (op == AluSra);

endmodule

// File: rtl/ixu_issue.sv
// Issue stage: decode, operand read with writeback bypass, two-entry skid buffer.
module ixu_issue
  import ixu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_X,
  output logic [31:0] out_Y,
  output logic [3:0]  out_op,
  output logic [4:0]  out_rd,
  output logic        illegal
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic         illegal_q, illegal_d;
  issue_entry_t main_q, main_d;
  issue_entry_t skid_q, skid_d;

  alu_op_e      dec_op;
  logic         dec_use_imm;
  logic [31:0]  dec_imm;
  logic         dec_is_shift;
  logic         dec_illegal;

  logic [31:0]  opa, opb, y_raw;
  issue_entry_t new_entry;
  logic         accept, push, pop;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  ixu_decode u_decode (
    .instr    (in_instr),
    .op       (dec_op),
    .use_imm  (dec_use_imm),
    .imm      (dec_imm),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

  // Build the entry for the instruction currently offered upstream.
  always_comb begin
    opa   = read_operand(rs1_addr, rs1_data, wb_valid, wb_rd, wb_data);
    opb   = read_operand(rs2_addr, rs2_data, wb_valid, wb_rd, wb_data);
    y_raw = dec_use_imm ? dec_imm : opb;
    new_entry.x  = opa;
    new_entry.y  = dec_is_shift ? {27'b0, y_raw[4:0]} : y_raw;
    new_entry.op = dec_op;
    new_entry.rd = in_instr[11:7];
  end

  assign accept    = in_valid && in_ready_q && !flush;
  assign push      = accept && !dec_illegal;
  assign out_valid = (state_q != StEmpty);
  assign pop       = out_valid && out_ready;

  // Skid-buffer next state; illegal instructions are consumed without being stored.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          main_d  = new_entry;
        end
      end
      StOne: begin
        if (push && pop) begin
          main_d = new_entry;
        end else if (push) begin
          state_d = StFull;
          skid_d  = new_entry;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
    in_ready_d = (state_d != StFull);
    illegal_d  = accept && dec_illegal;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      illegal_q  <= illegal_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready = in_ready_q;
  assign illegal  = illegal_q;
  assign out_X    = main_q.x;
  assign out_Y    = main_q.y;
  assign out_op   = main_q.op;
  assign out_rd   = main_q.rd;

endmodule

// File: tb/tb_ixu_issue.sv
// Directed self-checking bench for ixu_issue.
module tb_ixu_issue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_instr, rs1_data, rs2_data, wb_data;
  logic [4:0]  rs1_addr, rs2_addr, wb_rd;
  logic        wb_valid, out_valid, out_ready, illegal;
  logic [31:0] out_X, out_Y;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ixu_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_X     (out_X),
    .out_Y     (out_Y),
    .out_op    (out_op),
    .out_rd    (out_rd),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
    in_instr = instr;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
    drive(instr, r1, r2);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] op, input logic [4:0] rd);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".X"}, out_X, x);
    check({tag, ".Y"}, out_Y, y);
    check({tag, ".op"}, 32'(out_op), 32'(op));
    check({tag, ".rd"}, 32'(out_rd), 32'(rd));
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  op;
    logic [4:0]  rd;
  } vec_t;

  vec_t        legal_v[8];
  logic [31:0] illegal_v[5];

  initial begin
    // rs1_data = 12345678, rs2_data = 000000F0 for all table vectors
    legal_v[0] = '{32'h00F0C393, 32'h12345678, 32'h0000000F, 4'd2, 5'd7};   // xori x7,x1,15
    legal_v[1] = '{32'hFFB02413, 32'h00000000, 32'hFFFFFFFB, 4'd8, 5'd8};   // slti x8,x0,-5
    legal_v[2] = '{32'h40008093, 32'h12345678, 32'h00000400, 4'd0, 5'd1};   // addi imm[11:5]=20
    legal_v[3] = '{32'h00309093, 32'h12345678, 32'h00000003, 4'd5, 5'd1};   // slli x1,x1,3
    legal_v[4] = '{32'h00208333, 32'h12345678, 32'h000000F0, 4'd0, 5'd6};   // add x6,x1,x2
    legal_v[5] = '{32'h0020B4B3, 32'h12345678, 32'h000000F0, 4'd9, 5'd9};   // sltu x9,x1,x2
    legal_v[6] = '{32'h0020F5B3, 32'h12345678, 32'h000000F0, 4'd4, 5'd11};  // and x11,x1,x2
    legal_v[7] = '{32'h0020D633, 32'h12345678, 32'h00000010, 4'd6, 5'd12};  // srl x12,x1,x2
    illegal_v[0] = 32'h8030D213;  // srai with funct7 40
    illegal_v[1] = 32'h02208333;  // mul
    illegal_v[2] = 32'h40309093;  // slli with funct7 20
    illegal_v[3] = 32'h00012083;  // lw
    illegal_v[4] = 32'h4020C0B3;  // xor with funct7 20

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    rs1_data = '0; rs2_data = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.ready", 32'(in_ready), 32'd1);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.X", out_X, 32'd0);
    check("rst.Y", out_Y, 32'd0);
    check("rst.op", 32'(out_op), 32'd0);
    check("rst.rd", 32'(out_rd), 32'd0);
    rst_n = 1'b1;
    step();

    // addi x5,x0,-1; x0 read ignores data and a writeback to x0
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    drive(32'hFFF00293, 32'h55, 32'h66);
    check("addi.rs1_addr", 32'(rs1_addr), 32'd0);
    check("addi.rs2_addr", 32'(rs2_addr), 32'd31);
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    chk_out("addi", 32'h0, 32'hFFFFFFFF, 4'd0, 5'd5);
    pop_one();
    check("addi.drain", 32'(out_valid), 32'd0);

    // sub x3,x1,x2 with bypass on x1
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h10;
    drive(32'h402081B3, 32'h99, 32'h3);
    check("sub.rs1_addr", 32'(rs1_addr), 32'd1);
    check("sub.rs2_addr", 32'(rs2_addr), 32'd2);
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    chk_out("sub", 32'h10, 32'h3, 4'd1, 5'd3);
    pop_one();

    // sra x4,x1,x2: shift amount masked to 5 bits
    send(32'h4020D233, 32'h80000000, 32'h00000123);
    chk_out("sra", 32'h80000000, 32'h3, 4'd7, 5'd4);
    pop_one();

    for (int i = 0; i < 8; i++) begin
      send(legal_v[i].instr, 32'h12345678, 32'h000000F0);
      chk_out($sformatf("legal%0d", i), legal_v[i].x, legal_v[i].y, legal_v[i].op,
              legal_v[i].rd);
      check($sformatf("legal%0d.illegal", i), 32'(illegal), 32'd0);
      pop_one();
    end

    for (int i = 0; i < 5; i++) begin
      send(illegal_v[i], 32'h1, 32'h2);
      check($sformatf("ill%0d.pulse", i), 32'(illegal), 32'd1);
      check($sformatf("ill%0d.valid", i), 32'(out_valid), 32'd0);
      check($sformatf("ill%0d.ready", i), 32'(in_ready), 32'd1);
      step();
      check($sformatf("ill%0d.end", i), 32'(illegal), 32'd0);
    end

    // Three back-to-back with out_ready low: two accepted, third held off
    drive(32'h00100093, 32'h0, 32'h0);
    step();
    check("b2b.ready1", 32'(in_ready), 32'd1);
    check("b2b.valid1", 32'(out_valid), 32'd1);
    drive(32'h00200113, 32'h0, 32'h0);
    step();
    check("b2b.ready2", 32'(in_ready), 32'd0);
    drive(32'h00300193, 32'h0, 32'h0);
    step();
    check("b2b.ready3", 32'(in_ready), 32'd0);
    chk_out("b2b.hold", 32'h0, 32'h1, 4'd0, 5'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("b2b.second", 32'h0, 32'h2, 4'd0, 5'd2);
    check("b2b.ready4", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b0;
    check("b2b.empty", 32'(out_valid), 32'd0);

    // ONE + accept + out_ready stays ONE with the newer entry
    send(32'h00100093, 32'h0, 32'h0);
    drive(32'h00200113, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk_out("thru", 32'h0, 32'h2, 4'd0, 5'd2);
    check("thru.ready", 32'(in_ready), 32'd1);
    pop_one();
    check("thru.empty", 32'(out_valid), 32'd0);

    // Flush in FULL with an instruction offered
    send(32'h00100093, 32'h0, 32'h0);
    send(32'h00200113, 32'h0, 32'h0);
    check("fl.full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(32'h00012083, 32'h0, 32'h0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.valid", 32'(out_valid), 32'd0);
    check("fl.ready", 32'(in_ready), 32'd1);
    check("fl.illegal", 32'(illegal), 32'd0);

    // Flush in ONE drops an offered load without an illegal pulse
    send(32'h00100093, 32'h0, 32'h0);
    flush = 1'b1;
    drive(32'h00012083, 32'h0, 32'h0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1.valid", 32'(out_valid), 32'd0);
    check("fl1.illegal", 32'(illegal), 32'd0);
    step();
    check("fl1.illegal2", 32'(illegal), 32'd0);

    // Reset in FULL
    send(32'h00100093, 32'h0, 32'h0);
    send(32'h00200113, 32'h0, 32'h0);
    rst_n = 1'b0;
    step();
    check("rf.valid", 32'(out_valid), 32'd0);
    check("rf.ready", 32'(in_ready), 32'd1);
    check("rf.illegal", 32'(illegal), 32'd0);
    check("rf.X", out_X, 32'd0);
    check("rf.Y", out_Y, 32'd0);
    rst_n = 1'b1;
    step();
    check("rf.after", 32'(out_valid), 32'd0);

    // Load while ONE: illegal pulse, buffered entry untouched
    send(32'hFFF00293, 32'h0, 32'h0);
    send(32'h00012083, 32'h0, 32'h0);
    check("ld.pulse", 32'(illegal), 32'd1);
    check("ld.ready", 32'(in_ready), 32'd1);
    chk_out("ld.keep", 32'h0, 32'hFFFFFFFF, 4'd0, 5'd5);
    step();
    check("ld.end", 32'(illegal), 32'd0);
    check("ld.still", 32'(out_valid), 32'd1);
    pop_one();
    check("ld.empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
